vx_tag_flush_seq: RTL and testbench

Write-side sequencer for a cache bank's tag store. It generates the tag store's fill/flush write stream and owns the invalidate sweep: after reset and on each flush request it walks every line index and issues one flush write per cycle. Outside a sweep it passes fill requests from the memory-response path through as registered fill writes. It sits between the bank's fill path and the tag store write port, and stalls fills while a sweep is in progress.

---
 rtl/vx_tag_flush_seq.sv | 119 +++++++++++
 tb/tb_vx_tag_flush_seq.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_tag_flush_seq.sv
// vx_tag_flush_seq: write-side sequencer for a cache bank's tag store.
// After reset, and whenever a flush is requested, it walks every line index
// and issues one invalidate write per cycle. Between sweeps it forwards fill
// requests from the memory-response path as registered fill writes, and it
// holds fills off while a sweep is running.
module vx_tag_flush_seq #(
   parameter int LINES_PER_BANK  = 64,
   parameter int LINE_ADDR_WIDTH = 26
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush_req,
   input  logic                       fill_valid,
   input  logic [LINE_ADDR_WIDTH-1:0] fill_addr,
   output logic                       fill_ready,
   output logic                       tag_fill,
   output logic                       tag_flush,
   output logic [LINE_ADDR_WIDTH-1:0] tag_addr,
   output logic                       busy,
   output logic                       flush_done
);

   localparam int LINE_SELECT_BITS = $clog2(LINES_PER_BANK);

   // Index of the final line in a sweep; the counter wraps to zero after it
   // because the line count is a power of two.
   localparam logic [LINE_SELECT_BITS-1:0] CNT_LAST = LINE_SELECT_BITS'(LINES_PER_BANK - 1);
   localparam logic [LINE_SELECT_BITS-1:0] CNT_ONE  = LINE_SELECT_BITS'(1);

   typedef enum logic [0:0] {
      ST_FLUSH = 1'b0,
      ST_IDLE  = 1'b1
   } state_t;

   state_t                      state_r;
   logic [LINE_SELECT_BITS-1:0] cnt_r;
   logic                        pending_r;
   logic                        fill_accept_s;
   logic                        cnt_last_s;

   // Status decoded straight from the state register, so neither fill_valid
   // nor flush_req can reach fill_ready or busy combinationally.
   assign fill_ready    = (state_r == ST_IDLE);
   assign busy          = (state_r == ST_FLUSH);
   assign fill_accept_s = fill_valid & fill_ready;
   assign cnt_last_s    = (cnt_r == CNT_LAST);

   // Sweep/fill sequencer: state, sweep counter, pending flag and the
   // registered tag-store write strobes.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r    <= ST_FLUSH;
         cnt_r      <= '0;
         pending_r  <= 1'b0;
         tag_fill   <= 1'b0;
         tag_flush  <= 1'b0;
         tag_addr   <= '0;
         flush_done <= 1'b0;
      end else begin
         case (state_r)
            ST_FLUSH: begin
               tag_fill  <= 1'b0;
               tag_flush <= 1'b1;
               tag_addr  <= LINE_ADDR_WIDTH'(cnt_r);
               cnt_r     <= cnt_r + CNT_ONE;
               if (cnt_last_s) begin
                  flush_done <= 1'b1;
                  pending_r  <= 1'b0;
                  // A request arriving on the final index folds into the
                  // same follow-on sweep as one already pending.
                  if (pending_r || flush_req) begin
                     state_r <= ST_FLUSH;
                  end else begin
                     state_r <= ST_IDLE;
                  end
               end else begin
                  flush_done <= 1'b0;
                  state_r    <= ST_FLUSH;
                  if (flush_req) begin
                     pending_r <= 1'b1;
                  end else begin
                     pending_r <= pending_r;
                  end
               end
            end
            ST_IDLE: begin
               tag_flush  <= 1'b0;
               flush_done <= 1'b0;
               cnt_r      <= '0;
               pending_r  <= 1'b0;
               // A fill accepted alongside a flush request still lands first;
               // the sweep's index 0 write follows on the next edge.
               if (fill_accept_s) begin
                  tag_fill <= 1'b1;
                  tag_addr <= fill_addr;
               end else begin
                  tag_fill <= 1'b0;
                  tag_addr <= tag_addr;
               end
               if (flush_req) begin
                  state_r <= ST_FLUSH;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            default: begin
               state_r    <= ST_FLUSH;
               cnt_r      <= '0;
               pending_r  <= 1'b0;
               tag_fill   <= 1'b0;
               tag_flush  <= 1'b0;
               tag_addr   <= '0;
               flush_done <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vx_tag_flush_seq.sv
// Self-checking bench for vx_tag_flush_seq with an 8-line bank. A behavioural
// model tracks sweep progress and the expected write stream; directed
// scenarios follow the test plan and a randomized run closes out.
module tb_vx_tag_flush_seq;

   localparam int N  = 8;
   localparam int AW = 26;

   logic          clk = 1'b0;
   logic          reset;
   logic          flush_req;
   logic          fill_valid;
   logic [AW-1:0] fill_addr;
   logic          fill_ready;
   logic          tag_fill;
   logic          tag_flush;
   logic [AW-1:0] tag_addr;
   logic          busy;
   logic          flush_done;

   int checks   = 0;
   int failures = 0;

   // model state: sweep progress and expected registered outputs
   bit            m_sweeping;
   int            m_pos;
   bit            m_want;
   logic          e_fill;
   logic          e_flush;
   logic          e_done;
   logic [AW-1:0] e_addr;

   logic [AW+4:0] obs_vec;
   logic [AW+4:0] exp_vec;

   vx_tag_flush_seq #(
      .LINES_PER_BANK (N),
      .LINE_ADDR_WIDTH(AW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .flush_req (flush_req),
      .fill_valid(fill_valid),
      .fill_addr (fill_addr),
      .fill_ready(fill_ready),
      .tag_fill  (tag_fill),
      .tag_flush (tag_flush),
      .tag_addr  (tag_addr),
      .busy      (busy),
      .flush_done(flush_done)
   );

   always #5 clk = ~clk;

   // address only matters while a write strobe is high
   assign obs_vec = {tag_fill, tag_flush, flush_done, busy, fill_ready,
                     (tag_fill | tag_flush) ? tag_addr : {AW{1'b0}}};
   assign exp_vec = {e_fill, e_flush, e_done, m_sweeping, ~m_sweeping,
                     (e_fill | e_flush) ? e_addr : {AW{1'b0}}};

   task automatic model_reset();
      m_sweeping = 1'b1;
      m_pos      = 0;
      m_want     = 1'b0;
      e_fill     = 1'b0;
      e_flush    = 1'b0;
      e_done     = 1'b0;
      e_addr     = '0;
   endtask

   // one clock edge of behaviour: a sweep emits index m_pos, otherwise fills pass
   task automatic model_edge(input logic req, input logic fv, input logic [AW-1:0] fa);
      if (m_sweeping) begin
         e_fill  = 1'b0;
         e_flush = 1'b1;
         e_addr  = AW'(m_pos);
         e_done  = (m_pos == N - 1);
         if (req) m_want = 1'b1;
         if (m_pos == N - 1) begin
            m_pos      = 0;
            m_sweeping = m_want;
            m_want     = 1'b0;
         end else begin
            m_pos = m_pos + 1;
         end
      end else begin
         e_flush = 1'b0;
         e_done  = 1'b0;
         if (fv) begin
            e_fill = 1'b1;
            e_addr = fa;
         end else begin
            e_fill = 1'b0;
         end
         if (req) m_sweeping = 1'b1;
      end
   endtask

   task automatic step(input logic req, input logic fv, input logic [AW-1:0] fa);
      flush_req  = req;
      fill_valid = fv;
      fill_addr  = fa;
      @(posedge clk);
      model_edge(req, fv, fa);
      #1;
   endtask

   task automatic test_reset();
      reset      = 1'b1;
      flush_req  = 1'b0;
      fill_valid = 1'b0;
      fill_addr  = '0;
      #2;
      reset = 1'b0;
      model_reset();
      #1;
      checks++;
      if ({tag_fill, tag_flush, tag_addr, flush_done, busy, fill_ready} !==
          {1'b0, 1'b0, {AW{1'b0}}, 1'b0, 1'b1, 1'b0}) begin
         failures++;
         $display("FAIL reset_values: got %h expected %h",
                  {tag_fill, tag_flush, tag_addr, flush_done, busy, fill_ready},
                  {1'b0, 1'b0, {AW{1'b0}}, 1'b0, 1'b1, 1'b0});
      end
      @(posedge clk);
      #1;
      reset = 1'b1;
      for (int i = 0; i < N; i++) begin
         step(1'b0, 1'b0, '0);
         checks++;
         if (obs_vec !== exp_vec) begin
            failures++;
            $display("FAIL reset_sweep_model[%0d]: got %h expected %h", i, obs_vec, exp_vec);
         end
         checks++;
         if (tag_flush !== 1'b1 || tag_fill !== 1'b0 || tag_addr !== AW'(i) ||
             flush_done !== (i == N - 1) || busy !== (i != N - 1)) begin
            failures++;
            $display("FAIL reset_sweep_index[%0d]: got flush=%b fill=%b addr=%0d done=%b busy=%b",
                     i, tag_flush, tag_fill, tag_addr, flush_done, busy);
         end
      end
      step(1'b0, 1'b0, '0);
      checks++;
      if (tag_flush !== 1'b0 || busy !== 1'b0 || fill_ready !== 1'b1 || flush_done !== 1'b0) begin
         failures++;
         $display("FAIL reset_sweep_end: got flush=%b busy=%b ready=%b done=%b expected 0 0 1 0",
                  tag_flush, busy, fill_ready, flush_done);
      end
   endtask

   task automatic test_single_fill();
      step(1'b0, 1'b1, AW'(32'h1234));
      checks++;
      if (tag_fill !== 1'b1 || tag_addr !== AW'(32'h1234) || tag_flush !== 1'b0 || obs_vec !== exp_vec) begin
         failures++;
         $display("FAIL single_fill: got fill=%b addr=%h flush=%b expected 1 1234 0",
                  tag_fill, tag_addr, tag_flush);
      end
      step(1'b0, 1'b0, '0);
      checks++;
      if (tag_fill !== 1'b0 || obs_vec !== exp_vec) begin
         failures++;
         $display("FAIL single_fill_drop: got fill=%b expected 0", tag_fill);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, AW'(32'h10 + i));
         checks++;
         if (tag_fill !== 1'b1 || tag_addr !== AW'(32'h10 + i) || fill_ready !== 1'b1 || obs_vec !== exp_vec) begin
            failures++;
            $display("FAIL b2b_fill[%0d]: got fill=%b addr=%h expected 1 %h",
                     i, tag_fill, tag_addr, 32'h10 + i);
         end
      end
      step(1'b0, 1'b0, '0);
      checks++;
      if (tag_fill !== 1'b0) begin
         failures++;
         $display("FAIL b2b_end: got fill=%b expected 0", tag_fill);
      end
   endtask

   task automatic test_fill_and_flush();
      step(1'b1, 1'b1, AW'(32'h55));
      checks++;
      if (tag_fill !== 1'b1 || tag_addr !== AW'(32'h55) || tag_flush !== 1'b0 ||
          busy !== 1'b1 || fill_ready !== 1'b0) begin
         failures++;
         $display("FAIL fill_then_flush_first: got fill=%b addr=%h flush=%b busy=%b ready=%b",
                  tag_fill, tag_addr, tag_flush, busy, fill_ready);
      end
      // fills offered during the sweep must be ignored
      for (int i = 0; i < N; i++) begin
         step(1'b0, 1'b1, AW'($urandom));
         checks++;
         if (tag_flush !== 1'b1 || tag_fill !== 1'b0 || tag_addr !== AW'(i) ||
             flush_done !== (i == N - 1) || (i < N - 1 && fill_ready !== 1'b0) ||
             obs_vec !== exp_vec) begin
            failures++;
            $display("FAIL fill_then_flush_sweep[%0d]: got %h expected %h", i, obs_vec, exp_vec);
         end
      end
      fill_valid = 1'b0;
   endtask

   task automatic test_pending_sweep();
      int flush_cnt;
      int done_cnt;
      flush_cnt = 0;
      done_cnt  = 0;
      step(1'b1, 1'b0, '0);
      checks++;
      if (busy !== 1'b1 || tag_flush !== 1'b0) begin
         failures++;
         $display("FAIL pending_start: got busy=%b flush=%b expected 1 0", busy, tag_flush);
      end
      for (int k = 0; k < 20; k++) begin
         step((k == 3) || (k == 7), 1'b0, '0);
         if (tag_flush === 1'b1) flush_cnt++;
         if (flush_done === 1'b1) done_cnt++;
         checks++;
         if (obs_vec !== exp_vec) begin
            failures++;
            $display("FAIL pending_model[%0d]: got %h expected %h", k, obs_vec, exp_vec);
         end
      end
      checks++;
      if (flush_cnt !== 16 || done_cnt !== 2 || busy !== 1'b0) begin
         failures++;
         $display("FAIL pending_totals: got flushes=%0d dones=%0d busy=%b expected 16 2 0",
                  flush_cnt, done_cnt, busy);
      end
   endtask

   task automatic test_reset_mid_sweep();
      step(1'b1, 1'b0, '0);
      for (int i = 0; i < 6; i++) step(1'b0, 1'b0, '0);
      checks++;
      if (tag_flush !== 1'b1 || tag_addr !== AW'(5)) begin
         failures++;
         $display("FAIL midreset_setup: got flush=%b addr=%0d expected 1 5", tag_flush, tag_addr);
      end
      #2;
      reset = 1'b0;
      model_reset();
      #1;
      checks++;
      if ({tag_fill, tag_flush, tag_addr, flush_done, busy, fill_ready} !==
          {1'b0, 1'b0, {AW{1'b0}}, 1'b0, 1'b1, 1'b0}) begin
         failures++;
         $display("FAIL midreset_async: got %h expected %h",
                  {tag_fill, tag_flush, tag_addr, flush_done, busy, fill_ready},
                  {1'b0, 1'b0, {AW{1'b0}}, 1'b0, 1'b1, 1'b0});
      end
      @(posedge clk);
      #1;
      checks++;
      if (tag_flush !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL midreset_hold: got flush=%b busy=%b expected 0 1", tag_flush, busy);
      end
      reset = 1'b1;
      for (int i = 0; i < N; i++) begin
         step(1'b0, 1'b0, '0);
         checks++;
         if (tag_flush !== 1'b1 || tag_addr !== AW'(i) || flush_done !== (i == N - 1) ||
             obs_vec !== exp_vec) begin
            failures++;
            $display("FAIL midreset_resweep[%0d]: got flush=%b addr=%0d done=%b",
                     i, tag_flush, tag_addr, flush_done);
         end
      end
      step(1'b0, 1'b0, '0);
      checks++;
      if (tag_flush !== 1'b0 || fill_ready !== 1'b1) begin
         failures++;
         $display("FAIL midreset_end: got flush=%b ready=%b expected 0 1", tag_flush, fill_ready);
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         step($urandom_range(0, 29) == 0, 1'($urandom_range(0, 1)), AW'($urandom));
         checks++;
         if (obs_vec !== exp_vec || (tag_fill & tag_flush) !== 1'b0) begin
            failures++;
            $display("FAIL random[%0d]: got %h expected %h", k, obs_vec, exp_vec);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_fill();
      test_back_to_back();
      test_fill_and_flush();
      test_pending_sweep();
      test_reset_mid_sweep();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
